// File: rtl/apb_pkg.sv
// Shared APB master definitions: transfer FSM states and pprot bit positions.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int PROT_PRIV  = 0;
    localparam int PROT_NSEC  = 1;
    localparam int PROT_INSTR = 2;

endpackage

// File: rtl/apb_wdt.sv
// ACCESS-phase wait watchdog: counts consecutive stalled cycles and flags the
// cycle in which the count would reach TIMEOUT. TIMEOUT=0 disables it.
module apb_wdt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_inputs;
        assign unused_inputs = &{1'b0, clk, resetn, clr, en};
        assign expired       = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(TIMEOUT + 1);

        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr) begin
                cnt_d = '0;
            end else if (en) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // Fires in the stalled cycle that brings the count up to TIMEOUT.
        assign expired = en && (cnt_q == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: accepts one command, runs SETUP/ACCESS with
// optional wait timeout, and returns a one-cycle registered response pulse.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    output logic [2:0]        pprot,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
        $error("apb_master_ctrl: DATA_W must be 8, 16 or 32");
    end
    if (ADDR_W < 1 || ADDR_W > 32) begin : g_bad_addr_w
        $error("apb_master_ctrl: ADDR_W must be in 1..32");
    end

    apb_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [STRB_W-1:0] pstrb_q, pstrb_d;
    logic [2:0]        pprot_q, pprot_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              wdt_clr, wdt_en, wdt_expired;

    assign wdt_en = (state_q == ACCESS) && !pready;

    apb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    always_comb begin
        state_d       = state_q;
        psel_d        = 1'b0;
        penable_d     = 1'b0;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wdt_clr       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // cmd_ready_q stays low for the first edge after reset release.
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pprot_d  = cmd_prot;
                    wdt_clr  = 1'b1;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                end else if (wdt_expired) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign pprot       = pprot_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed and randomized transfers against a
// transaction-level model of the expected APB phases and responses.
module tb_apb_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        bit          err;
    } cmd_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
    logic          pready = 1'b0, pslverr = 1'b0;
    logic [DW-1:0] prdata = '0;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    // Expected held values of the APB request and response registers.
    logic          e_pwrite;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata;
    logic [SW-1:0] e_pstrb;
    logic [2:0]    e_pprot;
    logic [DW-1:0] e_rdata;
    logic          e_err, e_to;

    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        e_pwrite = 0; e_paddr = '0; e_pwdata = '0; e_pstrb = '0; e_pprot = '0;
        e_rdata = '0; e_err = 0; e_to = 0;
    endtask

    task automatic chk_apb(input string ph);
        chk({ph, "_pwrite"}, pwrite, e_pwrite);
        chk({ph, "_paddr"}, paddr, e_paddr);
        chk({ph, "_pwdata"}, pwdata, e_pwdata);
        chk({ph, "_pstrb"}, pstrb, e_pstrb);
        chk({ph, "_pprot"}, pprot, e_pprot);
    endtask

    task automatic chk_rsp_hold(input string ph);
        chk({ph, "_rsp_valid"}, rsp_valid, 0);
        chk({ph, "_rsp_rdata"}, rsp_rdata, e_rdata);
        chk({ph, "_rsp_err"}, rsp_err, e_err);
        chk({ph, "_rsp_timeout"}, rsp_timeout, e_to);
    endtask

    task automatic drive(input cmd_t c);
        cmd_write = c.w; cmd_addr = c.addr; cmd_wdata = c.wdata;
        cmd_strb = c.strb; cmd_prot = c.prot;
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.w = 1'($urandom_range(0, 1));
        c.addr = $urandom; c.wdata = $urandom; c.rdata = $urandom;
        c.strb = 4'($urandom); c.prot = 3'($urandom);
        c.waits = $urandom_range(0, 6);
        c.err = ($urandom_range(0, 3) == 0);
        return c;
    endfunction

    task automatic idle_cycles(input int n);
        cmd_valid = 0;
        for (int i = 0; i < n; i++) begin
            pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            step();
            chk("idle_psel", psel, 0);
            chk("idle_penable", penable, 0);
            chk("idle_cmd_ready", cmd_ready, 1);
            chk_apb("idle");
            chk_rsp_hold("idle");
        end
        pready = 0; pslverr = 0;
    endtask

    // One transfer from command offer to the response cycle; leaves time in the
    // response cycle. With chain=1, cmd_valid stays high carrying nxt.
    task automatic xfer(input cmd_t c, input bit chain, input cmd_t nxt, output int acc);
        bit tmo;
        int n_acc;
        tmo   = (c.waits + 1 > TO);
        n_acc = tmo ? TO : c.waits + 1;
        chk("offer_cmd_ready", cmd_ready, 1);
        drive(c);
        cmd_valid = 1;
        step();
        acc = cyc;
        e_pwrite = c.w; e_paddr = c.addr; e_pwdata = c.wdata;
        e_pstrb = c.w ? c.strb : '0; e_pprot = c.prot;
        if (chain) begin
            drive(nxt);
        end else begin
            cmd_valid = 0;
            cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        end
        pready = 1'($urandom); pslverr = 1; prdata = $urandom;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk_apb("setup");
        chk_rsp_hold("setup");
        for (int k = 1; k <= n_acc; k++) begin
            step();
            pready  = (k == c.waits + 1);
            pslverr = pready ? c.err : 1'b1;
            prdata  = pready ? c.rdata : $urandom;
            chk("access_psel", psel, 1);
            chk("access_penable", penable, 1);
            chk("access_cmd_ready", cmd_ready, 0);
            chk("access_rsp_valid", rsp_valid, 0);
            chk_apb("access");
        end
        step();
        pready = 0; pslverr = 0;
        if (tmo) begin
            e_rdata = '0; e_err = 1; e_to = 1;
        end else begin
            e_rdata = c.w ? '0 : c.rdata; e_err = c.err; e_to = 0;
        end
        chk("rsp_psel", psel, 0);
        chk("rsp_penable", penable, 0);
        chk("rsp_cmd_ready", cmd_ready, 1);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_timeout", rsp_timeout, e_to);
        chk("rsp_latency", cyc - acc, n_acc + 1);
        chk_apb("rsp");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        cmd_t c, n, dummy, b2b[3];
        int   a0, a1, a2;
        bit   ch;

        clear_model();
        dummy = rand_cmd();
        #2 resetn = 0;
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_psel", psel, 0);
        chk("reset_penable", penable, 0);
        chk_apb("reset");
        chk_rsp_hold("reset");
        step();
        chk("reset_edge_cmd_ready", cmd_ready, 0);
        resetn = 1;
        idle_cycles(2);

        // Zero-wait write.
        c = '{w:1, addr:32'h10, wdata:32'hDEADBEEF, rdata:32'h0, strb:4'hF, prot:3'h0, waits:0, err:0};
        xfer(c, 0, dummy, a0);
        idle_cycles(1);

        // Read with 3 wait states.
        c = '{w:0, addr:32'h0000_0A40, wdata:32'h5555_AAAA, rdata:32'h12345678, strb:4'hF, prot:3'h2, waits:3, err:0};
        xfer(c, 0, dummy, a0);
        idle_cycles(1);

        // Slave error at completion, and a clean write with pslverr during waits.
        c = '{w:1, addr:32'h20, wdata:32'h1, rdata:32'h0, strb:4'h3, prot:3'h1, waits:2, err:1};
        xfer(c, 0, dummy, a0);
        c = '{w:1, addr:32'h24, wdata:32'h2, rdata:32'h0, strb:4'hC, prot:3'h4, waits:2, err:0};
        xfer(c, 0, dummy, a0);
        idle_cycles(1);

        // Timeout with pready never arriving, then pready on the last allowed cycle.
        c = '{w:0, addr:32'h30, wdata:32'h0, rdata:32'hCAFE_F00D, strb:4'h0, prot:3'h0, waits:20, err:0};
        xfer(c, 0, dummy, a0);
        c = '{w:0, addr:32'h34, wdata:32'h0, rdata:32'hBEEF_0001, strb:4'h0, prot:3'h0, waits:TO-1, err:0};
        xfer(c, 0, dummy, a0);
        idle_cycles(1);

        // Back-to-back with cmd_valid held high.
        for (int i = 0; i < 3; i++) begin
            b2b[i] = rand_cmd();
            b2b[i].waits = 0;
        end
        xfer(b2b[0], 1, b2b[1], a0);
        xfer(b2b[1], 1, b2b[2], a1);
        xfer(b2b[2], 0, dummy, a2);
        chk("b2b_accept_gap1", a1 - a0, 3);
        chk("b2b_accept_gap2", a2 - a1, 3);
        idle_cycles(1);

        // Reset while stalled in ACCESS.
        c = '{w:0, addr:32'h44, wdata:32'h0, rdata:32'h0, strb:4'h0, prot:3'h0, waits:10, err:0};
        drive(c);
        cmd_valid = 1;
        step();
        cmd_valid = 0;
        pready = 0;
        step();
        step();
        chk("pre_reset_penable", penable, 1);
        #2 resetn = 0;
        #1;
        clear_model();
        chk("midrst_psel", psel, 0);
        chk("midrst_penable", penable, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        chk_apb("midrst");
        chk_rsp_hold("midrst");
        step();
        chk_rsp_hold("midrst_edge");
        resetn = 1;
        idle_cycles(1);
        c = '{w:0, addr:32'h48, wdata:32'h0, rdata:32'h600D_D00D, strb:4'h0, prot:3'h5, waits:3, err:0};
        xfer(c, 0, dummy, a0);

        // Randomized transfers, some chained.
        c = rand_cmd();
        for (int i = 0; i < 40; i++) begin
            n  = rand_cmd();
            ch = (i < 39) && ($urandom_range(0, 1) == 1);
            xfer(c, ch, n, a0);
            if (!ch) idle_cycles($urandom_range(0, 2));
            c = n;
        end
        idle_cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
